// File: rtl/axis_frame_writer_pkg.sv
// Shared types and constants for the AXI-Stream ping-pong frame writer.
package axis_frame_pkg;

  // Capture FSM: FILL accepts beats, STALL holds off while both banks are full
  typedef enum logic [0:0] {
    FILL  = 1'b0,
    STALL = 1'b1
  } frame_state_e;

  localparam int FRAME_CNT_W = 16;

  // RAM address is {bank, ch, sample_addr}
  function automatic int frame_addr_w(input int log2_depth, input int log2_ch);
    return 1 + log2_ch + log2_depth;
  endfunction

endpackage

// File: rtl/axis_frame_writer_addr_gen.sv
// Beat position counters and RAM address formation for axis_frame_writer.
// Define BIT_REVERSE_EN to store samples in bit-reversed order (FFT input);
// channel and bank fields are never reversed.
module frame_addr_gen
  import axis_frame_pkg::*;
#(
  parameter int LOG2_DEPTH = 6,
  parameter int LOG2_CH    = 0,
  parameter int ADDR_W     = frame_addr_w(LOG2_DEPTH, LOG2_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              advance,
  input  logic              restart,
  input  logic              bank,
  output logic [ADDR_W-1:0] addr,
  output logic              final_beat
);

  localparam int CNT_W = LOG2_CH + LOG2_DEPTH;

  // ch_cnt occupies the low LOG2_CH bits and sample_cnt the high LOG2_DEPTH
  // bits, so a single increment carries from channel wrap into sample count.
  logic [CNT_W-1:0]      beat_cnt;
  logic [LOG2_DEPTH-1:0] sample_cnt;
  logic [LOG2_DEPTH-1:0] sample_addr;

  assign sample_cnt = beat_cnt[CNT_W-1:LOG2_CH];
  assign final_beat = &beat_cnt;

  // Advance on every accepted beat; a tlast beat restarts the frame
  always_ff @(posedge clk) begin
    if (reset || (advance && restart)) begin
      beat_cnt <= '0;
    end else if (advance) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

`ifdef BIT_REVERSE_EN
  // Mirror the sample index across LOG2_DEPTH bits
  always_comb begin
    sample_addr = '0;
    for (int unsigned i = 0; i < LOG2_DEPTH; i++) begin
      sample_addr[i] = sample_cnt[LOG2_DEPTH-1-i];
    end
  end
`else
  // Natural sample order
  always_comb begin
    sample_addr = sample_cnt;
  end
`endif

  if (LOG2_CH > 0) begin : g_ch
    assign addr = {bank, beat_cnt[LOG2_CH-1:0], sample_addr};
  end else begin : g_no_ch
    assign addr = {bank, sample_addr};
  end

endmodule

// File: rtl/axis_frame_writer.sv
// AXI-Stream frame writer into a two-bank (ping-pong) block RAM with
// back-pressure, frame-complete signalling and tlast framing checks.
// Define BIT_REVERSE_EN for bit-reversed sample addressing within a bank.
module axis_frame_writer
  import axis_frame_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LOG2_DEPTH = 6,
  parameter int LOG2_CH    = 0,
  parameter int ADDR_W     = frame_addr_w(LOG2_DEPTH, LOG2_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic                   ram_we,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_din,
  output logic                   frame_done,
  output logic                   frame_bank,
  output logic                   frame_avail,
  input  logic                   frame_release,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   err_tlast_early,
  output logic                   err_tlast_missing,
  input  logic                   err_clear
);

  frame_state_e      state, state_next;
  logic [1:0]        full, full_next;
  logic              wr_bank, rd_bank;
  logic              hs, final_beat, complete, abort, release_ok;
  logic              complete_d;
  logic [ADDR_W-1:0] beat_addr;

  assign s_axis_tready = (state == FILL);
  assign hs            = s_axis_tvalid && s_axis_tready;
  assign complete      = hs && final_beat;
  assign abort         = hs && s_axis_tlast && !final_beat;
  // Announcement lags bank fill by a cycle, so also require a bank really full
  assign release_ok    = frame_release && frame_avail && (|full);

  frame_addr_gen #(
    .LOG2_DEPTH (LOG2_DEPTH),
    .LOG2_CH    (LOG2_CH),
    .ADDR_W     (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .advance    (hs),
    .restart    (s_axis_tlast),
    .bank       (wr_bank),
    .addr       (beat_addr),
    .final_beat (final_beat)
  );

  // Next bank occupancy and FSM; a release in the completion cycle can free
  // the bank we are about to switch to, in which case we keep filling.
  always_comb begin
    full_next = full;
    if (complete) full_next[wr_bank] = 1'b1;
    if (release_ok) full_next[rd_bank] = 1'b0;
    state_next = state;
    case (state)
      FILL:    if (complete && full_next[~wr_bank]) state_next = STALL;
      STALL:   if (release_ok) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // FSM, bank pointers and completed-frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FILL;
      full        <= '0;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      frame_count <= '0;
    end else begin
      state <= state_next;
      full  <= full_next;
      if (complete) begin
        wr_bank     <= ~wr_bank;
        frame_count <= frame_count + 1'b1;
      end
      if (release_ok) rd_bank <= ~rd_bank;
    end
  end

  // RAM write port and frame announcement registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_we      <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
      complete_d  <= 1'b0;
      frame_done  <= 1'b0;
      frame_avail <= 1'b0;
      frame_bank  <= 1'b0;
    end else begin
      ram_we <= hs;
      if (hs) begin
        ram_addr <= beat_addr;
        ram_din  <= s_axis_tdata;
      end
      complete_d  <= complete;
      frame_done  <= complete_d;
      frame_avail <= |full;
      frame_bank  <= rd_bank;
    end
  end

  // Sticky framing errors; a new error wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset) begin
      err_tlast_early   <= 1'b0;
      err_tlast_missing <= 1'b0;
    end else begin
      err_tlast_early   <= (err_tlast_early && !err_clear) || abort;
      err_tlast_missing <= (err_tlast_missing && !err_clear) || (complete && !s_axis_tlast);
    end
  end

endmodule

// File: tb/tb_axis_frame_writer.sv
// Self-checking bench for axis_frame_writer: a queue-based frame model checks
// the default-size instance every cycle, a second 4-channel instance is
// checked against hand-derived addresses, plus directed literal checks.
module tb_axis_frame_writer;

  localparam int NB = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [31:0] a_tdata, a_din;
  logic        a_tvalid, a_tready, a_tlast, a_we, a_done, a_bank, a_avail, a_rel;
  logic [6:0]  a_addr;
  logic [15:0] a_count;
  logic        a_eearly, a_emiss, a_eclr;

  logic [31:0] b_tdata, b_din;
  logic        b_tvalid, b_tready, b_tlast, b_we, b_done, b_bank, b_avail;
  logic [5:0]  b_addr;
  logic [15:0] b_count;
  logic        b_eearly, b_emiss;

  axis_frame_writer dut_a (
    .clk(clk), .reset(reset),
    .s_axis_tdata(a_tdata), .s_axis_tvalid(a_tvalid), .s_axis_tready(a_tready),
    .s_axis_tlast(a_tlast), .ram_we(a_we), .ram_addr(a_addr), .ram_din(a_din),
    .frame_done(a_done), .frame_bank(a_bank), .frame_avail(a_avail),
    .frame_release(a_rel), .frame_count(a_count),
    .err_tlast_early(a_eearly), .err_tlast_missing(a_emiss), .err_clear(a_eclr)
  );

  axis_frame_writer #(.DATA_W(32), .LOG2_DEPTH(3), .LOG2_CH(2)) dut_b (
    .clk(clk), .reset(reset),
    .s_axis_tdata(b_tdata), .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready),
    .s_axis_tlast(b_tlast), .ram_we(b_we), .ram_addr(b_addr), .ram_din(b_din),
    .frame_done(b_done), .frame_bank(b_bank), .frame_avail(b_avail),
    .frame_release(1'b0), .frame_count(b_count),
    .err_tlast_early(b_eearly), .err_tlast_missing(b_emiss), .err_clear(1'b0)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rev_bits(input int v, input int w);
    int r;
    r = v & ((1 << w) - 1);
`ifdef BIT_REVERSE_EN
    r = 0;
    for (int i = 0; i < w; i++) if (v[i]) r |= 1 << (w - 1 - i);
`endif
    return r;
  endfunction

  // ---------------- frame model for dut_a ----------------
  bit          m_live = 0;
  int          m_beat, m_wbank, m_count;
  int          m_fullq[$];
  bit          m_stall, m_eearly, m_emiss, m_pend_done;
  bit          x_we, x_done, x_avail, x_bank;
  logic [6:0]  x_addr;
  logic [31:0] x_din;

  always @(posedge clk) begin
    bit hs, rel, comp, e_set, m_set;
    if (reset) begin
      m_live = 1; m_beat = 0; m_wbank = 0; m_count = 0; m_fullq.delete();
      m_stall = 0; m_eearly = 0; m_emiss = 0; m_pend_done = 0;
      x_we = 0; x_done = 0; x_avail = 0; x_bank = 0; x_addr = '0; x_din = '0;
    end else if (m_live) begin
      rel   = a_rel && x_avail && (m_fullq.size() > 0);
      hs    = a_tvalid && !m_stall;
      comp  = 0; e_set = 0; m_set = 0;
      x_done  = m_pend_done;
      x_avail = m_fullq.size() > 0;
      if (x_avail) x_bank = m_fullq[0][0];
      x_we = hs;
      if (hs) begin
        x_addr = 7'(m_wbank * NB + rev_bits(m_beat, 6));
        x_din  = a_tdata;
        if (m_beat == NB - 1) begin
          comp = 1; m_set = !a_tlast; m_beat = 0;
        end else if (a_tlast) begin
          e_set = 1; m_beat = 0;
        end else begin
          m_beat++;
        end
      end
      m_eearly = (m_eearly && !a_eclr) || e_set;
      m_emiss  = (m_emiss && !a_eclr) || m_set;
      if (rel) begin
        void'(m_fullq.pop_front());
        m_stall = 0;
      end
      if (comp) begin
        m_fullq.push_back(m_wbank);
        m_wbank ^= 1;
        m_count = (m_count + 1) % 65536;
        foreach (m_fullq[i]) if (m_fullq[i] == m_wbank) m_stall = 1;
      end
      m_pend_done = comp;
    end
  end

  int logged [0:NB-1];

  // compare dut_a against the model every cycle
  always @(negedge clk) begin
    if (m_live) begin
      check("tready", a_tready, !m_stall);
      check("ram_we", a_we, x_we);
      if (x_we) begin
        check("ram_addr", a_addr, x_addr);
        check("ram_din", a_din, x_din);
      end
      check("frame_done", a_done, x_done);
      check("frame_avail", a_avail, x_avail);
      if (x_avail) check("frame_bank", a_bank, x_bank);
      check("frame_count", a_count, m_count);
      check("err_early", a_eearly, m_eearly);
      check("err_missing", a_emiss, m_emiss);
      if (a_we && a_din < NB) logged[a_din] = a_addr;
    end
  end

  // ---------------- dut_b address monitor ----------------
  int b_wr_cnt = 0, b_done_cnt = 0;
  always @(negedge clk) begin
    int k;
    if (!reset && b_we) begin
      k = int'(b_din);
      check("b_addr", b_addr, (k % 4) * 8 + rev_bits(k / 4, 3));
      b_wr_cnt++;
    end
    if (!reset && b_done) b_done_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic a_idle();
    a_tvalid = 0; a_tlast = 0;
  endtask

  task automatic a_send(input int data, input bit last, input bit rel);
    bit rdy;
    int n;
    n = 0;
    a_tdata = data; a_tlast = last; a_tvalid = 1; a_rel = rel;
    forever begin
      rdy = a_tready;
      @(posedge clk); #1;
      a_rel = 0;
      if (rdy) break;
      n++;
      if (n > 200) begin
        check("a_send_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic a_frame(input int base, input bit last_ok, input int rel_at);
    for (int i = 0; i < NB; i++) a_send(base + i, (i == NB - 1) && last_ok, i == rel_at);
    a_idle();
  endtask

  task automatic a_release();
    a_rel = 1; @(posedge clk); #1; a_rel = 0;
  endtask

  task automatic b_send(input int data, input bit last);
    bit rdy;
    int n;
    n = 0;
    b_tdata = data; b_tlast = last; b_tvalid = 1;
    forever begin
      rdy = b_tready;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 200) begin
        check("b_send_timeout", 0, 1);
        break;
      end
    end
  endtask

  initial begin
    reset = 1; a_tdata = '0; a_tvalid = 0; a_tlast = 0; a_rel = 0; a_eclr = 0;
    b_tdata = '0; b_tvalid = 0; b_tlast = 0;
    cycles(3);
    // reset values
    check("rst_tready", a_tready, 1);
    check("rst_we", a_we, 0);
    check("rst_addr", a_addr, 0);
    check("rst_din", a_din, 0);
    check("rst_done", a_done, 0);
    check("rst_avail", a_avail, 0);
    check("rst_count", a_count, 0);
    check("rst_errs", {a_eearly, a_emiss}, 0);
    reset = 0;
    cycles(1);

    // four channels x eight samples on dut_b
    for (int k = 0; k < 32; k++) b_send(k, k == 31);
    b_tvalid = 0; b_tlast = 0;
    cycles(3);
    check("b_writes", b_wr_cnt, 32);
    check("b_done_once", b_done_cnt, 1);
    check("b_count", b_count, 1);
    check("b_avail_bank", {b_avail, b_bank}, 2'b10);
    check("b_errs", {b_eearly, b_emiss, b_tready}, 3'b001);

    // single frame into bank 0
    a_frame(0, 1, -1);
    check("s1_last_we", a_we, 1);
    check("s1_last_addr", a_addr, 63);
    check("s1_done_early", a_done, 0);
    cycles(1);
    check("s1_done", a_done, 1);
    check("s1_avail", a_avail, 1);
    check("s1_bank", a_bank, 0);
    check("s1_count", a_count, 1);
    cycles(1);
    check("s1_done_pulse", a_done, 0);
`ifdef BIT_REVERSE_EN
    check("s1_sample1", logged[1], 32);
    check("s1_sample6", logged[6], 24);
`else
    check("s1_sample1", logged[1], 1);
    check("s1_sample6", logged[6], 6);
`endif
    a_release();
    cycles(2);
    check("s1_released", a_avail, 0);

    // early tlast on beat 10, then a frame missing tlast
    for (int i = 0; i <= 10; i++) a_send(100 + i, i == 10, 0);
    a_idle();
    check("s4_early", a_eearly, 1);
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      check("s4_no_done", a_done, 0);
    end
    a_send(200, 0, 0);
    check("s4_restart_addr", a_addr, 64);
    for (int i = 1; i < NB; i++) a_send(200 + i, 0, 0);
    a_idle();
    check("s4_missing", a_emiss, 1);
    cycles(2);
    check("s4_count", a_count, 2);
    check("s4_avail_bank", {a_avail, a_bank}, 2'b11);
    a_eclr = 1; cycles(1); a_eclr = 0;
    check("s4_cleared", {a_eearly, a_emiss}, 0);
    a_release();

    // two frames with no release, third frame waits for a release
    a_frame(300, 1, -1);
    a_frame(400, 1, -1);
    check("s3_stall", a_tready, 0);
    a_tdata = 500; a_tlast = 0; a_tvalid = 1;
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      check("s3_held", a_tready, 0);
    end
    a_release();
    check("s3_resume", a_tready, 1);
    a_frame(500, 1, -1);
    cycles(2);
    check("s3_bank", a_bank, 1);
    check("s3_count", a_count, 5);
    check("s3_stall_again", a_tready, 0);

    // final beat of bank 1 coincides with release of bank 0
    a_release();
    a_frame(600, 1, NB - 1);
    check("s5_no_stall", a_tready, 1);
    cycles(2);
    check("s5_avail_bank", {a_avail, a_bank}, 2'b11);
    check("s5_count", a_count, 6);

    // reset in the middle of a frame
    for (int i = 0; i < 20; i++) a_send(700 + i, 0, 0);
    a_tdata = 720; reset = 1;
    cycles(1);
    reset = 0; a_idle();
    check("s6_tready", a_tready, 1);
    check("s6_we", a_we, 0);
    check("s6_addr_din", {a_addr, a_din}, 0);
    check("s6_flags", {a_done, a_avail, a_eearly, a_emiss}, 0);
    check("s6_count", a_count, 0);
    a_send(800, 0, 0);
    check("s6_first_addr", a_addr, 0);
    for (int i = 1; i < NB; i++) a_send(800 + i, i == NB - 1, 0);
    a_idle();
    cycles(2);
    check("s6_count_after", a_count, 1);
    check("s6_avail_bank", {a_avail, a_bank}, 2'b10);
    cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_frame_writer.md
# axis_frame_writer

Parametrised AXI-Stream frame writer that accepts channel-interleaved sample beats and lands them in a ping-pong (two-bank) block RAM for a downstream FFT or correlator. It is the next-generation capture side of the ring-buffer → AXI master → AXI slave → block RAM → trigger FFT chain. It generalises the fixed 32×64 single-bank slave in data width, frame depth and channel count, and adds:

- back-pressure while both banks are full
- frame-complete signalling
- framing error detection

## Interface

Parameters:

- DATA_W, 32: sample/beat width in bits.
- LOG2_DEPTH, 6: log2 of samples per channel per frame (64).
- LOG2_CH, 0: log2 of channel count. Channels are interleaved per beat: ch0, ch1, …, chN-1, then the next sample.
- ADDR_W, 1+LOG2_CH+LOG2_DEPTH: derived; RAM address width.

Ports:

- clk, in, 1: the single clock.
- reset, in, 1: synchronous, active-high reset.
- s_axis_tdata, in, DATA_W: sample beat.
- s_axis_tvalid, in, 1: beat valid.
- s_axis_tready, out, 1: beat accepted when tvalid&&tready at a rising clk edge.
- s_axis_tlast, in, 1: marks the final beat of a frame.
- ram_we, out, 1: RAM write enable.
- ram_addr, out, ADDR_W: {bank, ch, sample_addr}.
- ram_din, out, DATA_W: RAM write data.
- frame_done, out, 1: one-cycle pulse when a bank becomes full.
- frame_bank, out, 1: oldest full bank, which the consumer reads; valid while frame_avail=1.
- frame_avail, out, 1: at least one bank is full.
- frame_release, in, 1: one-cycle pulse; consumer has finished with frame_bank.
- frame_count, out, 16: completed frames, wraps at 65535→0.
- err_tlast_early, out, 1: sticky error flag.
- err_tlast_missing, out, 1: sticky error flag.
- err_clear, in, 1: clears both error flags.

## Operation

- State machine with two states: FILL and STALL.
  - FILL: s_axis_tready=1.
  - STALL: s_axis_tready=0.
  - tready is a decode of the state register only, with no combinational path from tvalid.
- Counters:
  - ch_cnt is LOG2_CH bits; sample_cnt is LOG2_DEPTH bits.
  - On each handshake ch_cnt increments. When ch_cnt wraps, sample_cnt increments.
  - The final beat is ch_cnt=all-ones and sample_cnt=all-ones.
- Write bank: wr_bank toggles on every frame completion.
- Bank tracking:
  - full[1:0] holds one flag per bank.
  - rd_bank points to the oldest full bank.
  - frame_avail = |full; frame_bank = rd_bank.
- Frame completion on the final beat:
  - Set full[wr_bank], toggle wr_bank, clear both counters, increment frame_count.
  - If the new wr_bank is already full, go to STALL.
- Leaving STALL: frame_release clears full[rd_bank] and toggles rd_bank. STALL returns to FILL on the cycle after the release.
- Simultaneous completion and release in the same cycle:
  - Both take effect.
  - If the released bank is the new wr_bank, stay in FILL.
- frame_release while frame_avail=0 is ignored.
- tlast rules:
  - tlast on a non-final beat: set err_tlast_early and abort the frame. Counters go to 0, the same wr_bank is refilled, and there is no frame_done. The aborted beat is still written.
  - Final beat without tlast: set err_tlast_missing; the frame still completes. Sample count governs framing.
- Error flags: err_clear clears them. If an error sets in the same cycle as err_clear, the set wins.
- Reset:
  - Mid-frame data is discarded.
  - State=FILL, counters=0, wr_bank=0, rd_bank=0, full=00, frame_count=0, errors=0.

## Timing

- Reset values: s_axis_tready=1, ram_we=0, ram_addr=0, ram_din=0, frame_done=0, frame_bank=0, frame_avail=0, frame_count=0, both error flags 0.
- Write latency: a handshake at edge N produces ram_we/ram_addr/ram_din registered at edge N+1, held for one cycle.
- frame_done:
  - Pulses for the cycle following the final ram_we, i.e. 2 cycles after the final handshake.
  - frame_avail rises in the same cycle, so data is in RAM before it is announced.
- Throughput: one beat per clk in FILL; a frame takes 2^(LOG2_CH+LOG2_DEPTH) cycles minimum.
- Back-pressure timing:
  - s_axis_tready falls in the cycle after the final handshake that filled the second bank.
  - s_axis_tready rises 1 cycle after frame_release.

## Configuration

- BIT_REVERSE_EN defined: sample_addr = bit-reverse of sample_cnt over LOG2_DEPTH bits, so the bank holds FFT input in bit-reversed order.
- BIT_REVERSE_EN undefined: sample_addr = sample_cnt (natural order).
- ch and bank address fields are never reversed.

## Structure

- Package axis_frame_pkg holds:
  - state encoding (FILL, STALL)
  - the ADDR_W derivation
  - frame_count width constant (16)
- One sub-module, frame_addr_gen, holds:
  - ch_cnt/sample_cnt counters
  - the final-beat decode
  - optional bit reversal
  - the {bank, ch, sample_addr} concatenation
- The top level holds the FSM, bank tracking, error flags and output registers.

## Test plan

All scenarios use DATA_W=32 unless stated.

1. Single frame, LOG2_DEPTH=6, LOG2_CH=0, continuous tvalid, data 0..63, tlast on beat 63 → 64 writes to addr 0..63 with din=addr, frame_done 2 cycles after beat 63, frame_bank=0, frame_count=1. With BIT_REVERSE_EN defined, sample 1 lands at addr 32 and sample 6 at addr 24.
2. Four channels, LOG2_CH=2, LOG2_DEPTH=3, 32 beats → beat k is written to {0, k%4, k/4}; frame_done once.
3. Three frames with no release → frames 0 and 1 fill banks 0 and 1. tready drops after beat 63 of frame 1. Release frame 0 → tready=1 one cycle later; frame 2 fills bank 0; frame_bank=1.
4. tlast on beat 10 → err_tlast_early=1, no frame_done, next frame writes from addr 0 of the same bank. Later, a final beat without tlast → err_tlast_missing=1, frame completes. Then err_clear → both flags 0.
5. Final beat of the second bank coincides with frame_release of bank 0 → no stall, tready stays 1, full=10 after the edge.
6. Reset asserted at beat 20 → all outputs return to reset values next cycle; the following frame starts at bank 0, addr 0, and frame_count restarts at 0.
